// File: rtl/mfp_ahb_simple_master.sv
// AHB-Lite initiator issuing single word read/write transfers from a local command port.
// One transfer in flight; handles wait states, two-cycle ERROR and an optional data-phase timeout.
module mfp_ahb_simple_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter int unsigned TMO_W = 10
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [TMO_W-1:0] wait_cnt;
    logic [31:0]      wdata_q;
    logic             accept;
    logic             misaligned;
    logic             done;
    logic             tmo_hit;

    assign HSIZE      = 3'b010;
    assign HBURST     = 3'b000;
    assign accept     = cmd_valid && cmd_ready;
    assign misaligned = (cmd_addr[1:0] != 2'b00);
    assign done       = (state == S_DATA) && HREADY;
    // Fires on the edge that would record the TIMEOUT_CYCLES-th wait state.
    assign tmo_hit    = (TIMEOUT_CYCLES != 0) && (state == S_DATA)
                        && !HREADY && (wait_cnt == TMO_LAST);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (accept && !misaligned) begin
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                if (HREADY) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (done || tmo_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == S_IDLE);
        HTRANS    = (state == S_ADDR) ? 2'b10 : 2'b00;
        HWDATA    = (state == S_DATA && HWRITE) ? wdata_q : 32'h0;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HADDR       <= 32'h0;
            HWRITE      <= 1'b0;
            wdata_q     <= 32'h0;
            wait_cnt    <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= 32'h0;
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                if (misaligned) begin
                    rsp_valid   <= 1'b1;
                    rsp_err     <= 1'b1;
                    rsp_timeout <= 1'b0;
                    rsp_rdata   <= 32'h0;
                end else begin
                    HADDR   <= cmd_addr;
                    HWRITE  <= cmd_write;
                    wdata_q <= cmd_wdata;
                end
            end
            if (state == S_DATA) begin
                if (HREADY) begin
                    rsp_valid   <= 1'b1;
                    rsp_err     <= HRESP;
                    rsp_timeout <= 1'b0;
                    rsp_rdata   <= (!HWRITE && !HRESP) ? HRDATA : 32'h0;
                    wait_cnt    <= '0;
                end else if (tmo_hit) begin
                    rsp_valid   <= 1'b1;
                    rsp_err     <= 1'b0;
                    rsp_timeout <= 1'b1;
                    rsp_rdata   <= 32'h0;
                    wait_cnt    <= '0;
                end else begin
                    wait_cnt <= wait_cnt + TMO_W'(1);
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mfp_ahb_simple_master.sv
// Directed bench for mfp_ahb_simple_master: write, waited read, ERROR,
// misaligned, timeout and mid-transfer reset, each step hand-timed.
module tb_mfp_ahb_simple_master;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    int total = 0;
    int bad = 0;

    mfp_ahb_simple_master #(
        .TIMEOUT_CYCLES(4),
        .TMO_W(10)
    ) dut (
        .HCLK(HCLK),
        .HRESETn(HRESETn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .HADDR(HADDR),
        .HTRANS(HTRANS),
        .HWRITE(HWRITE),
        .HSIZE(HSIZE),
        .HBURST(HBURST),
        .HWDATA(HWDATA),
        .HRDATA(HRDATA),
        .HREADY(HREADY),
        .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [31:0] a,
                         input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    initial begin
        HRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        HRDATA    = 32'h0;
        HREADY    = 1'b1;
        HRESP     = 1'b0;
        tick();
        tick();

        // reset state
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_htrans", HTRANS, 32'h0);
        chk("rst_hwrite", HWRITE, 32'h0);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk("rst_rsp_valid", rsp_valid, 32'h0);
        chk("rst_rsp_err", rsp_err, 32'h0);
        chk("rst_rsp_tmo", rsp_timeout, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_cmd_ready", cmd_ready, 32'h1);
        chk("hsize", HSIZE, 32'h2);
        chk("hburst", HBURST, 32'h0);
        HRESETn = 1'b1;
        tick();

        // zero-wait write
        issue(1'b1, 32'hBF80_0000, 32'h0000_A5A5);
        chk("w_ready", cmd_ready, 32'h1);
        tick();
        cmd_valid = 1'b0;
        chk("w_htrans_a", HTRANS, 32'h2);
        chk("w_hwrite", HWRITE, 32'h1);
        chk("w_haddr", HADDR, 32'hBF80_0000);
        chk("w_ready_a", cmd_ready, 32'h0);
        tick();
        chk("w_htrans_d", HTRANS, 32'h0);
        chk("w_hwdata", HWDATA, 32'h0000_A5A5);
        chk("w_valid_d", rsp_valid, 32'h0);
        tick();
        chk("w_valid", rsp_valid, 32'h1);
        chk("w_err", rsp_err, 32'h0);
        chk("w_rdata", rsp_rdata, 32'h0);
        chk("w_ready_r", cmd_ready, 32'h1);
        chk("w_hwdata_idle", HWDATA, 32'h0);
        tick();
        chk("w_valid_pulse", rsp_valid, 32'h0);

        // read with two wait states
        issue(1'b0, 32'h0000_1000, 32'hFFFF_FFFF);
        tick();
        cmd_valid = 1'b0;
        chk("r_htrans_a", HTRANS, 32'h2);
        chk("r_hwrite", HWRITE, 32'h0);
        tick();
        HREADY = 1'b0;
        chk("r_hwdata", HWDATA, 32'h0);
        chk("r_haddr_d", HADDR, 32'h0000_1000);
        tick();
        chk("r_wait1_valid", rsp_valid, 32'h0);
        chk("r_haddr_w1", HADDR, 32'h0000_1000);
        tick();
        chk("r_wait2_valid", rsp_valid, 32'h0);
        HREADY = 1'b1;
        HRDATA = 32'h1234_5678;
        tick();
        chk("r_valid", rsp_valid, 32'h1);
        chk("r_rdata", rsp_rdata, 32'h1234_5678);
        chk("r_err", rsp_err, 32'h0);
        tick();

        // slave ERROR, with one address-phase wait state first
        issue(1'b0, 32'h0000_2000, 32'h0);
        tick();
        cmd_valid = 1'b0;
        HREADY = 1'b0;
        chk("e_htrans_a", HTRANS, 32'h2);
        tick();
        chk("e_htrans_held", HTRANS, 32'h2);
        chk("e_haddr_held", HADDR, 32'h0000_2000);
        HREADY = 1'b1;
        tick();
        chk("e_htrans_d", HTRANS, 32'h0);
        HREADY = 1'b0;
        HRESP  = 1'b1;
        HRDATA = 32'hDEAD_BEEF;
        tick();
        chk("e_valid_1st", rsp_valid, 32'h0);
        HREADY = 1'b1;
        tick();
        HRESP = 1'b0;
        chk("e_valid", rsp_valid, 32'h1);
        chk("e_err", rsp_err, 32'h1);
        chk("e_rdata", rsp_rdata, 32'h0);
        chk("e_ready", cmd_ready, 32'h1);
        tick();

        // misaligned address
        issue(1'b0, 32'h0000_0002, 32'h0);
        chk("m_htrans_req", HTRANS, 32'h0);
        tick();
        cmd_valid = 1'b0;
        chk("m_htrans", HTRANS, 32'h0);
        chk("m_valid", rsp_valid, 32'h1);
        chk("m_err", rsp_err, 32'h1);
        chk("m_ready", cmd_ready, 32'h1);
        tick();
        chk("m_valid_pulse", rsp_valid, 32'h0);
        chk("m_htrans_after", HTRANS, 32'h0);

        // timeout after four wait states
        issue(1'b0, 32'h0000_3000, 32'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t_wait_valid", rsp_valid, 32'h0);
            chk("t_wait_ready", cmd_ready, 32'h0);
        end
        tick();
        chk("t_valid", rsp_valid, 32'h1);
        chk("t_timeout", rsp_timeout, 32'h1);
        chk("t_rdata", rsp_rdata, 32'h0);
        chk("t_err", rsp_err, 32'h0);
        chk("t_ready", cmd_ready, 32'h1);
        HREADY = 1'b1;
        tick();
        chk("t_valid_pulse", rsp_valid, 32'h0);
        chk("t_timeout_hold", rsp_timeout, 32'h1);

        // reset asserted during data phase
        issue(1'b1, 32'h0000_4000, 32'h0000_1111);
        tick();
        cmd_valid = 1'b0;
        tick();
        HREADY = 1'b0;
        chk("x_hwdata", HWDATA, 32'h0000_1111);
        HRESETn = 1'b0;
        #1;
        chk("x_haddr", HADDR, 32'h0);
        chk("x_htrans", HTRANS, 32'h0);
        chk("x_hwrite", HWRITE, 32'h0);
        chk("x_hwdata0", HWDATA, 32'h0);
        chk("x_valid", rsp_valid, 32'h0);
        chk("x_timeout", rsp_timeout, 32'h0);
        chk("x_ready", cmd_ready, 32'h1);
        HREADY = 1'b1;
        tick();
        tick();
        HRESETn = 1'b1;
        tick();
        chk("x_no_rsp", rsp_valid, 32'h0);

        // back-to-back after reset
        issue(1'b1, 32'h0000_0010, 32'h0000_CAFE);
        tick();
        cmd_valid = 1'b0;
        chk("b_haddr1", HADDR, 32'h0000_0010);
        tick();
        chk("b_hwdata1", HWDATA, 32'h0000_CAFE);
        tick();
        chk("b_valid1", rsp_valid, 32'h1);
        chk("b_ready1", cmd_ready, 32'h1);
        issue(1'b0, 32'h0000_0020, 32'h0);
        HRDATA = 32'h55AA_55AA;
        tick();
        cmd_valid = 1'b0;
        chk("b_valid_gap", rsp_valid, 32'h0);
        chk("b_htrans2", HTRANS, 32'h2);
        chk("b_haddr2", HADDR, 32'h0000_0020);
        chk("b_hwrite2", HWRITE, 32'h0);
        tick();
        tick();
        chk("b_valid2", rsp_valid, 32'h1);
        chk("b_rdata2", rsp_rdata, 32'h55AA_55AA);
        chk("b_err2", rsp_err, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mfp_ahb_simple_master.md
Name: mfp_ahb_simple_master

Overview:
- AHB-Lite initiator that issues single 32-bit read/write transfers on behalf of a local command port (bench driver, debug bridge or DMA front end).
- Drives the same AHB-Lite bus that the GPIO, RAM and other slave blocks respond on, through the existing decoder/mux.
- Only one transfer is outstanding at a time; address and data phases of consecutive transfers never overlap.
- Handles slave wait states, two-cycle ERROR responses, and an optional data-phase timeout.

Parameters:
- TIMEOUT_CYCLES, 1023: maximum number of data-phase cycles with HREADY low before the transfer is abandoned; 0 disables the timeout.
- TMO_W, 10: width of the wait-state counter; must satisfy 2^TMO_W > TIMEOUT_CYCLES.

Ports:
- HCLK  in  1  bus clock; the only clock.
- HRESETn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command can be accepted; equals (state==IDLE).
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  byte address; bits [1:0] must be 00.
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  read data; 0 for writes, errors and timeouts.
- rsp_err  out  1  slave ERROR or misaligned address; qualified by rsp_valid.
- rsp_timeout  out  1  timeout occurred; qualified by rsp_valid.
- HADDR  out  32  AHB address.
- HTRANS  out  2  IDLE=00 or NONSEQ=10 only.
- HWRITE  out  1  AHB write.
- HSIZE  out  3  constant 3'b010 (word).
- HBURST  out  3  constant 3'b000 (SINGLE).
- HWDATA  out  32  AHB write data.
- HRDATA  in  32  AHB read data.
- HREADY  in  1  transfer done / slave ready.
- HRESP  in  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset (asynchronous, while HRESETn=0):
  - State = IDLE.
  - HADDR, HWDATA, rsp_rdata = 0; HTRANS = 00; HWRITE = 0.
  - rsp_valid, rsp_err, rsp_timeout = 0; wait counter = 0.
  - Reset mid-transfer abandons it with no response pulse.
- States: IDLE, ADDR, DATA.
- IDLE:
  - HTRANS = 00.
  - On cmd_valid & cmd_ready with cmd_addr[1:0]==00: latch address, write flag and wdata; drive HADDR/HWRITE from registers; next state ADDR.
  - With cmd_addr[1:0]!=00: no bus activity; next cycle rsp_valid=1, rsp_err=1; stay IDLE.
- ADDR:
  - HTRANS = NONSEQ.
  - At an edge with HREADY=1: go to DATA, set HTRANS=00.
  - If HREADY=0: hold all address-phase signals stable.
- DATA:
  - HWDATA = latched wdata for writes, 0 for reads.
  - The wait counter increments on each edge with HREADY=0.
  - At an edge with HREADY=1:
    - Capture HRDATA into rsp_rdata (reads only).
    - rsp_err = HRESP.
    - Pulse rsp_valid in the following cycle; go to IDLE.
  - HRESP=1 with HREADY=0 (first ERROR cycle): keep waiting; completion occurs on the second ERROR cycle (HREADY=1).
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES: rsp_valid=1, rsp_timeout=1, rsp_rdata=0; go to IDLE; counter cleared.
- Latency:
  - Zero-wait transfer: command accepted at edge 0, NONSEQ during cycle 1, data phase cycle 2, rsp_valid high in cycle 3.
  - Each wait state adds one cycle.
- cmd_ready is low in ADDR/DATA and during the rsp_valid cycle's preceding transition.
- A new command may be accepted in the same cycle rsp_valid is high, because state is IDLE.
- rsp_valid has no backpressure. rsp_* fields hold their values until the next completion; only rsp_valid pulses.
- cmd_* inputs are ignored when cmd_ready=0.

Test Plan:
- Zero-wait write: addr 0xBF800000, data 0x0000A5A5 -> HTRANS=10 for 1 cycle with HWRITE=1; HWDATA=0x0000A5A5 next cycle; rsp_valid 3 cycles after accept; rsp_err=0.
- Read with 2 wait states, HRDATA=0x12345678 -> HADDR held, HWDATA=0, rsp_valid 5 cycles after accept, rsp_rdata=0x12345678.
- Slave ERROR: data phase HRESP=1/HREADY=0, then HRESP=1/HREADY=1 -> rsp_valid=1, rsp_err=1, rsp_rdata=0, state IDLE.
- Misaligned cmd_addr=0x00000002 -> HTRANS stays 00; rsp_valid with rsp_err=1 one cycle later.
- Timeout with TIMEOUT_CYCLES=4 and HREADY stuck low -> rsp_timeout=1 after 4 wait cycles; cmd_ready high again the cycle after.
- HRESETn asserted during DATA -> all outputs 0 immediately; no rsp_valid; back-to-back commands afterwards complete normally.
